// File: rtl/cluster_pwr_pkg.sv
// Cluster power sequencer: shared state encoding, output bundle
// and parameter defaults.
package cluster_pwr_pkg;

  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned RST_CYCLES_DEF    = 8;
  localparam int unsigned ACK_TIMEOUT_DEF   = 1024;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_PU_SWITCH,
    ST_PU_SETTLE,
    ST_PU_RESET,
    ST_PU_UNCLAMP,
    ST_ON,
    ST_PD_CLKOFF,
    ST_PD_CLAMP,
    ST_PD_SWITCH,
    ST_ERR
  } cluster_pwr_state_e;

  typedef struct packed {
    logic ack;
    logic busy;
    logic err;
    logic switch_en;
    logic clamp;
    logic rst_n;
    logic clk_en;
  } cluster_pwr_out_t;

  localparam cluster_pwr_out_t OUT_RST = '{
    ack:       1'b0,
    busy:      1'b0,
    err:       1'b0,
    switch_en: 1'b0,
    clamp:     1'b1,
    rst_n:     1'b0,
    clk_en:    1'b0
  };

  function automatic cluster_pwr_out_t decode(
    input cluster_pwr_state_e s
  );
    cluster_pwr_out_t o;
    o = OUT_RST;
    unique case (s)
      ST_PU_SWITCH,
      ST_PU_SETTLE: begin
        o.switch_en = 1'b1;
        o.busy      = 1'b1;
      end
      ST_PU_RESET: begin
        o.switch_en = 1'b1;
        o.clk_en    = 1'b1;
        o.busy      = 1'b1;
      end
      // clamp drops one cycle ahead of reset release
      ST_PU_UNCLAMP: begin
        o.switch_en = 1'b1;
        o.clk_en    = 1'b1;
        o.clamp     = 1'b0;
        o.busy      = 1'b1;
      end
      ST_ON: begin
        o.switch_en = 1'b1;
        o.clk_en    = 1'b1;
        o.clamp     = 1'b0;
        o.rst_n     = 1'b1;
        o.ack       = 1'b1;
      end
      ST_PD_CLKOFF: begin
        o.switch_en = 1'b1;
        o.clamp     = 1'b0;
        o.rst_n     = 1'b1;
        o.ack       = 1'b1;
        o.busy      = 1'b1;
      end
      ST_PD_CLAMP: begin
        o.switch_en = 1'b1;
        o.ack       = 1'b1;
        o.busy      = 1'b1;
      end
      ST_PD_SWITCH: begin
        o.ack  = 1'b1;
        o.busy = 1'b1;
      end
      ST_ERR: begin
        o.err = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cluster_pwr_seq_if.sv
// Req/ack handshake between the SoC power manager and the
// cluster power sequencer.
interface cluster_pwr_seq_if;
  logic pwr_req_i;
  logic pwr_ack_o;
  logic busy_o;
  logic err_o;

  modport master (
    output pwr_req_i,
    input  pwr_ack_o,
    input  busy_o,
    input  err_o
  );

  modport slave (
    input  pwr_req_i,
    output pwr_ack_o,
    output busy_o,
    output err_o
  );
endinterface

// File: rtl/cluster_pwr_timer.sv
// Clearable saturating up-counter with compare-equal flag;
// the sequencer supplies the compare value for each state.
module cluster_pwr_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic [W-1:0] cmp_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)
      cnt_q <= '0;
    else if (clr_i)
      cnt_q <= '0;
    else if (cnt_q != '1)
      cnt_q <= cnt_q + W'(1);
  end

  assign hit_o = (cnt_q == cmp_i);

endmodule

// File: rtl/sync_cell.sv
// Generic multi-flop synchronizer for single-bit async inputs.
// Synchronous active-low reset clears the chain to 0.
module sync_cell #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ff_q <= '0;
    else         ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power-domain sequencer: switch, settle, reset, unclamp
// on power-up and the reverse on power-down.
module cluster_pwr_seq
  import cluster_pwr_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  cluster_pwr_seq_if.slave  pm,
  input  logic              switch_ack_i,
  output logic              switch_en_o,
  output logic              clamp_o,
  output logic              cluster_rst_no,
  output logic              clk_en_o
);

  localparam int unsigned MAX_SR =
    (SETTLE_CYCLES > RST_CYCLES) ? SETTLE_CYCLES : RST_CYCLES;
  localparam int unsigned CNT_MAX =
    (MAX_SR > ACK_TIMEOUT) ? MAX_SR : ACK_TIMEOUT;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);

  cluster_pwr_state_e state_q, state_d;
  cluster_pwr_out_t   out_q;
  logic               ack_s;
  logic               hit;
  logic [CW-1:0]      cmp;

  sync_cell #(.STAGES(2)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (switch_ack_i),
    .q_o    (ack_s)
  );

  // hit fires in the last cycle of a wait, so compare to N-1
  always_comb begin
    cmp = '0;
    unique case (state_q)
      ST_PU_SWITCH,
      ST_PD_SWITCH: cmp = CW'(ACK_TIMEOUT - 1);
      ST_PU_SETTLE: cmp = CW'(SETTLE_CYCLES - 1);
      ST_PU_RESET:  cmp = CW'(RST_CYCLES - 1);
      default:      cmp = '0;
    endcase
  end

  cluster_pwr_timer #(.W(CW)) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_d != state_q),
    .cmp_i  (cmp),
    .hit_o  (hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:
        if (pm.pwr_req_i) state_d = ST_PU_SWITCH;
      ST_PU_SWITCH:
        if (ack_s)        state_d = ST_PU_SETTLE;
        else if (hit)     state_d = ST_ERR;
      ST_PU_SETTLE:
        if (hit)          state_d = ST_PU_RESET;
      ST_PU_RESET:
        if (hit)          state_d = ST_PU_UNCLAMP;
      ST_PU_UNCLAMP:      state_d = ST_ON;
      ST_ON:
        if (!pm.pwr_req_i) state_d = ST_PD_CLKOFF;
      ST_PD_CLKOFF:       state_d = ST_PD_CLAMP;
      ST_PD_CLAMP:        state_d = ST_PD_SWITCH;
      ST_PD_SWITCH:
        if (!ack_s)       state_d = ST_OFF;
        else if (hit)     state_d = ST_ERR;
      ST_ERR:
        if (!pm.pwr_req_i && !ack_s) state_d = ST_OFF;
      default:            state_d = ST_OFF;
    endcase
  end

  // outputs register the decode of the next state, so they
  // change on the same edge as the state
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_OFF;
      out_q   <= OUT_RST;
    end else begin
      state_q <= state_d;
      out_q   <= decode(state_d);
    end
  end

  assign pm.pwr_ack_o   = out_q.ack;
  assign pm.busy_o      = out_q.busy;
  assign pm.err_o       = out_q.err;
  assign switch_en_o    = out_q.switch_en;
  assign clamp_o        = out_q.clamp;
  assign cluster_rst_no = out_q.rst_n;
  assign clk_en_o       = out_q.clk_en;

endmodule
